fcvt_sched: RTL and testbench
=============================

// Module: fcvt_sched
// PURPOSE
//  Shares one fixed-latency float->int converter datapath (ftoi-style: x, rm in;
//  y out LAT cycles later) between two requesters, e.g. the core FPU issue port
//  and the vector/batch port. Round-robin issue, one op per cycle, in-order
//  per-requester result FIFOs, and credit-based issue so no result is ever dropped.
// PARAMETERS
//  LAT    1  converter latency in cycles (cvt_x/cvt_rm sampled -> cvt_y valid), >=1
//  DEPTH  2  per-requester result FIFO depth (power of 2, >=1)
//  TAG_W  4  width of requester-supplied tag returned with each result
// PORTS
//  clk          in   1      clock; all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 op valid
//  req0_ready   out  1      requester 0 op accepted this cycle when valid&ready
//  req0_x       in   32     requester 0 IEEE-754 single operand
//  req0_rm      in   1      requester 0 rounding mode (0 nearest/trunc path, 1 floor)
//  req0_tag     in   TAG_W  requester 0 tag
//  req1_*       -    -      identical set for requester 1
//  res0_valid   out  1      requester 0 result FIFO non-empty
//  res0_ready   in   1      requester 0 pops head when valid&ready
//  res0_y       out  32     requester 0 head result (signed int32)
//  res0_tag     out  TAG_W  tag of head result
//  res1_*       -    -      identical set for requester 1
//  cvt_x        out  32     operand to converter (combinational from granted req)
//  cvt_rm       out  1      rounding mode to converter
//  cvt_y        in   32     converter result, corresponds to issue LAT cycles earlier
//  busy         out  1      any op in flight or any result FIFO non-empty
// BEHAVIOUR
//  - Reset: req*_ready=0, res*_valid=0, res*_y=0, res*_tag=0, busy=0, cvt_x=0,
//    cvt_rm=0; rr pointer=0 (req0 preferred); credits=DEPTH each; pipe empty.
//  - credit[i]: DEPTH - (in-flight ops for i) - (FIFO i occupancy). Range 0..DEPTH.
//    Issue to i: -1. Pop from FIFO i: +1. Both same cycle: unchanged. Capture into
//    FIFO does not change credit.
//  - eligible[i] = req_i_valid & credit[i]!=0. Grant: if both eligible, the one
//    the rr pointer names; else the single eligible one; else none.
//  - req_i_ready = grant==i (combinational; depends on valid — requesters must not
//    wait on ready before asserting valid). At most one ready per cycle.
//  - On grant: rr pointer := other requester. No grant: pointer unchanged.
//  - cvt_x/cvt_rm = granted req's x/rm; 0/0 when no grant.
//  - Issue pipe: LAT-stage shift register of {v, id, tag}, stage 0 loaded on the
//    issue edge. When stage LAT-1 has v=1 on a clock edge, cvt_y is written with
//    its tag into FIFO[id] at that edge. Credit guarantees FIFO never overflows.
//  - Latency: op accepted at edge N -> res_valid at edge N+LAT+1 if FIFO was empty
//    (visible cycle after capture). Throughput 1 op/cycle aggregate.
//  - FIFOs: in-order; simultaneous capture and pop on same FIFO allowed, incl. when
//    full (pop frees, capture fills) and when empty-with-capture (no bypass: pop
//    only when res_valid already high). Pointers wrap mod DEPTH.
//  - res_y/res_tag hold head value while valid&!ready (stable until popped).
//  - Results of one requester return in issue order; no ordering across requesters.
//  - busy = |pipe.v | res0_valid | res1_valid.
//  - rst mid-operation: pipe, FIFOs, credits, pointer cleared next edge; in-flight
//    converter outputs after reset are ignored (pipe v=0).
//  - No exceptions: converter saturation/NaN results passed through unmodified.
// TESTING
//  1 Single op: req0 x=0x3FC00000(1.5) rm=0 tag=3, res0_ready=1 -> res0_y=1, tag=3
//    at edge N+LAT+1; busy low one cycle later.
//  2 Contention: both valid every cycle, res ready=1 -> grants alternate 0,1,0,1;
//    each req gets 1 op/2 cycles; tags return in order per requester.
//  3 Backpressure: res0_ready=0, req0 streams 5 ops -> exactly DEPTH accepted
//    (req0_ready low after), req1 still served; raising res0_ready drains in order
//    and reopens req0.
//  4 Full FIFO pop+capture same edge with credit=0 -> no loss, no duplicate, credit
//    stays consistent (scoreboard count==issued).
//  5 Rounding path: req1 x=0xBFC00000(-1.5) rm=1 with reference ftoi model ->
//    res1_y=0xFFFFFFFE; x=0x4F000000 -> 0x7FFFFFFF passed through.
//  6 rst asserted with ops in flight and FIFOs full -> next cycle all outputs at
//    reset values, credits=DEPTH, new op completes normally.

Source files
------------

// File: rtl/fcvt_sched.sv
// Two-requester front end for a shared fixed-latency float->int converter:
// round-robin issue, credit-limited so every result has a slot in its requester's FIFO.
module fcvt_sched #(
    parameter int LAT   = 1,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic             req0_rm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic             req1_rm,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res0_valid,
    input  logic             res0_ready,
    output logic [31:0]      res0_y,
    output logic [TAG_W-1:0] res0_tag,
    output logic             res1_valid,
    input  logic             res1_ready,
    output logic [31:0]      res1_y,
    output logic [TAG_W-1:0] res1_tag,
    output logic [31:0]      cvt_x,
    output logic             cvt_rm,
    input  logic [31:0]      cvt_y,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    credit_r [2];
    logic             rr_r;
    logic [LAT-1:0]   pipe_v_r;
    logic [LAT-1:0]   pipe_id_r;
    logic [TAG_W-1:0] pipe_tag_r [LAT];
    logic [31:0]      fifo_y_r   [2][DEPTH];
    logic [TAG_W-1:0] fifo_tag_r [2][DEPTH];
    logic [PW-1:0]    wr_ptr_r   [2];
    logic [PW-1:0]    rd_ptr_r   [2];
    logic [CW-1:0]    cnt_r      [2];

    logic [1:0] elig_s;
    logic [1:0] grant_s;
    logic [1:0] res_valid_s;
    logic [1:0] res_ready_s;
    logic [1:0] pop_s;
    logic [1:0] cap_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Eligibility and round-robin grant; nothing is granted while reset is held
    always_comb begin
        elig_s[0] = !rst && req0_valid && (credit_r[0] != '0);
        elig_s[1] = !rst && req1_valid && (credit_r[1] != '0);
        case (elig_s)
            2'b11:   grant_s = rr_r ? 2'b10 : 2'b01;
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Steer the granted operand to the converter
    always_comb begin
        case (grant_s)
            2'b01: begin
                cvt_x  = req0_x;
                cvt_rm = req0_rm;
            end
            2'b10: begin
                cvt_x  = req1_x;
                cvt_rm = req1_rm;
            end
            default: begin
                cvt_x  = 32'd0;
                cvt_rm = 1'b0;
            end
        endcase
    end

    assign res_ready_s = {res1_ready, res0_ready};

    // FIFO status, pops, and which FIFO the retiring pipe stage targets
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            res_valid_s[i] = (cnt_r[i] != '0);
            pop_s[i]       = res_valid_s[i] && res_ready_s[i];
            cap_s[i]       = pipe_v_r[LAT-1] && (pipe_id_r[LAT-1] == 1'(i));
        end
    end

    // Head values are forced to zero when empty so reset shows clean outputs
    assign res0_valid = res_valid_s[0];
    assign res1_valid = res_valid_s[1];
    assign res0_y     = res_valid_s[0] ? fifo_y_r[0][rd_ptr_r[0]]   : 32'd0;
    assign res1_y     = res_valid_s[1] ? fifo_y_r[1][rd_ptr_r[1]]   : 32'd0;
    assign res0_tag   = res_valid_s[0] ? fifo_tag_r[0][rd_ptr_r[0]] : '0;
    assign res1_tag   = res_valid_s[1] ? fifo_tag_r[1][rd_ptr_r[1]] : '0;
    assign busy       = (|pipe_v_r) | (|res_valid_s);

    // Pointer, issue pipe, credits and result FIFOs
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r      <= 1'b0;
            pipe_v_r  <= '0;
            pipe_id_r <= '0;
            for (int s = 0; s < LAT; s++) begin
                pipe_tag_r[s] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                credit_r[i] <= CW'(DEPTH);
                cnt_r[i]    <= '0;
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
            end
        end else begin
            if (|grant_s) begin
                rr_r <= grant_s[0];
            end
            pipe_v_r[0]   <= |grant_s;
            pipe_id_r[0]  <= grant_s[1];
            pipe_tag_r[0] <= grant_s[1] ? req1_tag : req0_tag;
            for (int s = 1; s < LAT; s++) begin
                pipe_v_r[s]   <= pipe_v_r[s-1];
                pipe_id_r[s]  <= pipe_id_r[s-1];
                pipe_tag_r[s] <= pipe_tag_r[s-1];
            end
            // Capture leaves credit untouched: the slot was reserved at issue
            for (int i = 0; i < 2; i++) begin
                credit_r[i] <= credit_r[i] - CW'(grant_s[i]) + CW'(pop_s[i]);
                cnt_r[i]    <= cnt_r[i] + CW'(cap_s[i]) - CW'(pop_s[i]);
                if (cap_s[i]) begin
                    fifo_y_r[i][wr_ptr_r[i]]   <= cvt_y;
                    fifo_tag_r[i][wr_ptr_r[i]] <= pipe_tag_r[LAT-1];
                    wr_ptr_r[i]                <= ptr_inc(wr_ptr_r[i]);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_fcvt_sched.sv
// Scoreboard bench for fcvt_sched with a behavioural one-cycle ftoi converter
// and a table of hand-computed conversion vectors.
module tb_fcvt_sched;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_rm;
    logic [31:0]      req0_x;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_rm;
    logic [31:0]      req1_x;
    logic [TAG_W-1:0] req1_tag;
    logic             res0_valid, res0_ready, res1_valid, res1_ready;
    logic [31:0]      res0_y, res1_y;
    logic [TAG_W-1:0] res0_tag, res1_tag;
    logic [31:0]      cvt_x, cvt_y;
    logic             cvt_rm, busy;

    fcvt_sched #(.LAT(1), .DEPTH(2), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
        .req0_rm(req0_rm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
        .req1_rm(req1_rm), .req1_tag(req1_tag),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_y(res0_y), .res0_tag(res0_tag),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_y(res1_y), .res1_tag(res1_tag),
        .cvt_x(cvt_x), .cvt_rm(cvt_rm), .cvt_y(cvt_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference converter: truncation for rm=0, floor for rm=1, saturating
    function automatic logic [31:0] ftoi(input logic [31:0] x, input logic rm);
        logic [7:0]  e;
        logic [63:0] m, mag;
        logic        frac;
        int          sh;
        e    = x[30:23];
        m    = {40'd0, 1'b1, x[22:0]};
        sh   = int'(e) - 127;
        frac = 1'b0;
        mag  = 64'd0;
        if (e == 8'hFF && x[22:0] != 23'd0) return 32'h7FFF_FFFF;
        if (sh >= 31) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (e == 8'd0) begin
            frac = (x[22:0] != 23'd0);
        end else if (sh < 0) begin
            frac = 1'b1;
        end else if (sh >= 23) begin
            mag = m << (sh - 23);
        end else begin
            mag  = m >> (23 - sh);
            frac = ((m & ((64'd1 << (23 - sh)) - 64'd1)) != 64'd0);
        end
        if (rm && frac && x[31]) mag = mag + 64'd1;
        return x[31] ? 32'(-mag) : mag[31:0];
    endfunction

    logic [31:0] cvt_y_r = 32'd0;
    always @(posedge clk) cvt_y_r <= ftoi(cvt_x, cvt_rm);
    assign cvt_y = cvt_y_r;

    typedef struct packed {
        logic [31:0] x;
        logic        rm;
        logic [31:0] y;
    } vec_t;
    vec_t vt [12];

    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    logic [31:0] exp0, exp1;
    int n_chk = 0;
    int n_fail = 0;
    int seq0 = 0;
    int seq1 = 0;
    int b0, b1;
    bit a0, a1, exp_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Issue side: record the expected result of every accepted op
    always @(negedge clk) begin
        if (!rst && req0_valid && req0_ready) q0.push_back({exp0, req0_tag});
        if (!rst && req1_valid && req1_ready) q1.push_back({exp1, req1_tag});
    end

    // Result side: every pop is matched against the head expectation
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst && res0_valid && res0_ready) begin
            if (q0.size() == 0) chk("res0 unexpected pop", 64'd1, 64'd0);
            else begin
                e = q0.pop_front();
                chk("res0_y", 64'(res0_y), 64'(e[35:4]));
                chk("res0_tag", 64'(res0_tag), 64'(e[3:0]));
            end
        end
        if (!rst && res1_valid && res1_ready) begin
            if (q1.size() == 0) chk("res1 unexpected pop", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("res1_y", 64'(res1_y), 64'(e[35:4]));
                chk("res1_tag", 64'(res1_tag), 64'(e[3:0]));
            end
        end
    end

    task automatic set_req(input int r, input bit v, input int s);
        if (r == 0) begin
            req0_valid = v;
            req0_x     = vt[s % 12].x;
            req0_rm    = vt[s % 12].rm;
            req0_tag   = 4'(s);
            exp0       = vt[s % 12].y;
        end else begin
            req1_valid = v;
            req1_x     = vt[(s + 1) % 12].x;
            req1_rm    = vt[(s + 1) % 12].rm;
            req1_tag   = 4'(s);
            exp1       = vt[(s + 1) % 12].y;
        end
    endtask

    task automatic step(input bit v0, input bit v1);
        set_req(0, v0, seq0);
        set_req(1, v1, seq1);
        #1;
        a0 = req0_ready;
        a1 = req1_ready;
        @(posedge clk);
        #1;
        if (a0) seq0++;
        if (a1) seq1++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{32'h3FC0_0000, 1'b0, 32'h0000_0001};
        vt[1]  = '{32'hBFC0_0000, 1'b1, 32'hFFFF_FFFE};
        vt[2]  = '{32'h4F00_0000, 1'b0, 32'h7FFF_FFFF};
        vt[3]  = '{32'h4020_0000, 1'b0, 32'h0000_0002};
        vt[4]  = '{32'hC020_0000, 1'b0, 32'hFFFF_FFFE};
        vt[5]  = '{32'hC020_0000, 1'b1, 32'hFFFF_FFFD};
        vt[6]  = '{32'h3F00_0000, 1'b1, 32'h0000_0000};
        vt[7]  = '{32'hBF00_0000, 1'b1, 32'hFFFF_FFFF};
        vt[8]  = '{32'h42F6_0000, 1'b0, 32'h0000_007B};
        vt[9]  = '{32'h0000_0000, 1'b1, 32'h0000_0000};
        vt[10] = '{32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF};
        vt[11] = '{32'hCF00_0000, 1'b0, 32'h8000_0000};

        rst = 1'b1;
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        set_req(0, 1'b0, 0);
        set_req(1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset res0_valid", 64'(res0_valid), 64'd0);
        chk("reset res1_valid", 64'(res1_valid), 64'd0);
        chk("reset res0_y", 64'(res0_y), 64'd0);
        chk("reset res1_tag", 64'(res1_tag), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset cvt_x", {31'd0, cvt_rm, cvt_x}, 64'd0);
        rst = 1'b0;

        // Single op: 1.5 truncates to 1, tag 3
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        req0_valid = 1'b1;
        req0_x     = 32'h3FC0_0000;
        req0_rm    = 1'b0;
        req0_tag   = 4'd3;
        exp0       = 32'd1;
        #1;
        chk("single req0_ready", 64'(req0_ready), 64'd1);
        chk("single cvt_x", 64'(cvt_x), 64'h3FC0_0000);
        @(posedge clk); #1;
        seq0 = 1;
        req0_valid = 1'b0;
        chk("single in-flight res0_valid", 64'(res0_valid), 64'd0);
        chk("single in-flight busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("single res0_valid", 64'(res0_valid), 64'd1);
        chk("single res0_y", 64'(res0_y), 64'd1);
        chk("single res0_tag", 64'(res0_tag), 64'd3);
        @(posedge clk); #1;
        chk("single done res0_valid", 64'(res0_valid), 64'd0);
        chk("single done busy", 64'(busy), 64'd0);

        // Contention: pointer now names req1
        exp_g = 1'b1;
        repeat (8) begin
            step(1'b1, 1'b1);
            chk("contention grant", {62'd0, a0, a1}, exp_g ? 64'd1 : 64'd2);
            exp_g = !exp_g;
        end
        repeat (4) step(1'b0, 1'b0);
        chk("contention drained busy", 64'(busy), 64'd0);

        // Backpressure on requester 0
        res0_ready = 1'b0;
        b0 = seq0;
        b1 = seq1;
        repeat (8) step(seq0 < b0 + 5, seq1 < b1 + 3);
        chk("backpressure req0 accepted", 64'(seq0 - b0), 64'd2);
        chk("backpressure req1 accepted", 64'(seq1 - b1), 64'd3);
        set_req(0, 1'b1, seq0);
        #1;
        chk("backpressure req0_ready", 64'(req0_ready), 64'd0);
        @(posedge clk); #1;
        res0_ready = 1'b1;
        for (int k = 0; k < 30 && seq0 < b0 + 5; k++) step(1'b1, 1'b0);
        chk("backpressure drain accepted", 64'(seq0 - b0), 64'd5);
        repeat (4) step(1'b0, 1'b0);

        // One result held, one in flight, credit zero; pop and capture share an edge
        res0_ready = 1'b0;
        step(1'b1, 1'b0);
        chk("full issue 1", 64'(a0), 64'd1);
        step(1'b1, 1'b0);
        chk("full issue 2", 64'(a0), 64'd1);
        set_req(0, 1'b1, seq0);
        res0_ready = 1'b1;
        #1;
        chk("full credit zero ready", 64'(req0_ready), 64'd0);
        chk("full head valid", 64'(res0_valid), 64'd1);
        @(posedge clk); #1;
        chk("full after pop+capture valid", 64'(res0_valid), 64'd1);
        step(1'b1, 1'b0);
        chk("full credit returned", 64'(a0), 64'd1);
        repeat (4) step(1'b0, 1'b0);
        chk("full scoreboard empty", 64'(q0.size()), 64'd0);

        // Reset with ops in flight and results held
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        repeat (3) step(1'b1, 1'b1);
        rst = 1'b1;
        set_req(0, 1'b1, seq0);
        set_req(1, 1'b1, seq1);
        #1;
        chk("rst ready gated", {62'd0, req0_ready, req1_ready}, 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        chk("rst res valids", {62'd0, res0_valid, res1_valid}, 64'd0);
        chk("rst res0_y", 64'(res0_y), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        b0 = seq0;
        repeat (4) step(1'b1, 1'b0);
        chk("rst credits restored", 64'(seq0 - b0), 64'd2);
        res0_ready = 1'b1;
        res1_ready = 1'b1;

        for (int k = 0; k < 50 && busy; k++) step(1'b0, 1'b0);
        chk("final busy", 64'(busy), 64'd0);
        chk("final q0 empty", 64'(q0.size()), 64'd0);
        chk("final q1 empty", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
